// File: rtl/aes_cozucu.sv
// aes_cozucu: iterative AES-128 decryptor, one round per clock, valid/ready handshake.
// Defining AES_ANAHTAR_ONBELLEK_EN adds an rk10 cache that skips key expansion on a key hit.
module aes_cozucu #(
    parameter int unsigned TUR_SAYISI = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] sifre,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] blok,
    output logic         c_gecerli
);
    localparam logic [3:0] SonSayac = 4'(TUR_SAYISI - 1);
    localparam logic [3:0] TurSayi  = 4'(TUR_SAYISI);

    typedef enum logic [1:0] {StBos, StAnahtar, StTur} durum_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, y;
        x2  = gmul(x, x);
        x3  = gmul(x2, x);
        x6  = gmul(x3, x3);
        x12 = gmul(x6, x6);
        y   = gmul(x12, x3);
        for (int i = 0; i < 4; i++) y = gmul(y, y);
        return gmul(gmul(y, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic son);
        logic [7:0]   a [16];
        logic [7:0]   m [16];
        logic [7:0]   coef [4];
        logic [127:0] r;
        coef[0] = 8'h0e;
        coef[1] = 8'h0b;
        coef[2] = 8'h0d;
        coef[3] = 8'h09;
        // Byte n sits at row n%4, column n/4; a row-r byte comes from column (col - r).
        for (int n = 0; n < 16; n++) begin
            a[n] = inv_sbox(s[127 - 8 * (4 * (((n / 4) - (n % 4)) & 3) + (n % 4)) -: 8])
                   ^ rk[127 - 8 * n -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                m[4 * c + j] = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    m[4 * c + j] = m[4 * c + j] ^ gmul(a[4 * c + k], coef[(k - j) & 3]);
                end
            end
        end
        for (int n = 0; n < 16; n++) r[127 - 8 * n -: 8] = son ? a[n] : m[n];
        return r;
    endfunction

    durum_t       durum_q, durum_d;
    logic [3:0]   sayac_q, sayac_d;
    logic [127:0] key_q, key_d, st_q, st_d, blok_q, blok_d;
    logic         c_q, c_d;
    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3, p0, p1, p2, p3;
    logic [127:0] ileri, geri, tur_sonuc;

`ifdef AES_ANAHTAR_ONBELLEK_EN
    logic [127:0] ob_key_q, ob_key_d, ob_rk_q, ob_rk_d;
    logic         ob_val_q, ob_val_d, atla_q, atla_d;
`endif

    // Forward step for key expansion, inverse step for unwinding during rounds.
    always_comb begin
        w0    = key_q[127:96];
        w1    = key_q[95:64];
        w2    = key_q[63:32];
        w3    = key_q[31:0];
        t     = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(sayac_q + 4'd1), 24'h0};
        n0    = w0 ^ t;
        n1    = w1 ^ n0;
        n2    = w2 ^ n1;
        n3    = w3 ^ n2;
        ileri = {n0, n1, n2, n3};
        p3    = w3 ^ w2;
        p2    = w2 ^ w1;
        p1    = w1 ^ w0;
        p0    = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(TurSayi - sayac_q), 24'h0};
        geri  = {p0, p1, p2, p3};
        tur_sonuc = inv_round(st_q, geri, sayac_q == SonSayac);
    end

    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        key_d   = key_q;
        st_d    = st_q;
        blok_d  = blok_q;
        c_d     = 1'b0;
        hazir   = 1'b0;
`ifdef AES_ANAHTAR_ONBELLEK_EN
        ob_key_d = ob_key_q;
        ob_rk_d  = ob_rk_q;
        ob_val_d = ob_val_q;
        atla_d   = atla_q;
`endif
        unique case (durum_q)
            StBos: begin
                hazir = 1'b1;
                if (g_gecerli) begin
                    st_d    = sifre;
                    sayac_d = '0;
                    durum_d = StAnahtar;
`ifdef AES_ANAHTAR_ONBELLEK_EN
                    if (ob_val_q && anahtar == ob_key_q) begin
                        key_d  = ob_rk_q;
                        atla_d = 1'b1;
                    end else begin
                        key_d    = anahtar;
                        ob_key_d = anahtar;
                        ob_val_d = 1'b0;
                    end
`else
                    key_d = anahtar;
`endif
                end
            end
            StAnahtar: begin
`ifdef AES_ANAHTAR_ONBELLEK_EN
                if (atla_q) begin
                    st_d    = st_q ^ key_q;
                    sayac_d = '0;
                    durum_d = StTur;
                    atla_d  = 1'b0;
                end else
`endif
                begin
                    key_d   = ileri;
                    sayac_d = sayac_q + 4'd1;
                    if (sayac_q == SonSayac) begin
                        st_d    = st_q ^ ileri;
                        sayac_d = '0;
                        durum_d = StTur;
`ifdef AES_ANAHTAR_ONBELLEK_EN
                        ob_rk_d  = ileri;
                        ob_val_d = 1'b1;
`endif
                    end
                end
            end
            StTur: begin
                key_d   = geri;
                st_d    = tur_sonuc;
                sayac_d = sayac_q + 4'd1;
                if (sayac_q == SonSayac) begin
                    blok_d  = tur_sonuc;
                    c_d     = 1'b1;
                    durum_d = StBos;
                end
            end
            default: durum_d = StBos;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q <= StBos;
            sayac_q <= '0;
            key_q   <= '0;
            st_q    <= '0;
            blok_q  <= '0;
            c_q     <= 1'b0;
`ifdef AES_ANAHTAR_ONBELLEK_EN
            ob_key_q <= '0;
            ob_rk_q  <= '0;
            ob_val_q <= 1'b0;
            atla_q   <= 1'b0;
`endif
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            key_q   <= key_d;
            st_q    <= st_d;
            blok_q  <= blok_d;
            c_q     <= c_d;
`ifdef AES_ANAHTAR_ONBELLEK_EN
            ob_key_q <= ob_key_d;
            ob_rk_q  <= ob_rk_d;
            ob_val_q <= ob_val_d;
            atla_q   <= atla_d;
`endif
        end
    end

    assign blok      = blok_q;
    assign c_gecerli = c_q;

endmodule

// File: tb/tb_aes_cozucu.sv
// Bench for aes_cozucu: textbook AES model with cycle-level scoreboard plus FIPS-197 vectors.
// Follows AES_ANAHTAR_ONBELLEK_EN to pick the expected cache-hit latency.
module tb_aes_cozucu;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] anahtar = '0;
    logic [127:0] sifre = '0;
    logic         g_gecerli = 1'b0;
    logic         hazir, c_gecerli;
    logic [127:0] blok;

    always #5 clk = ~clk;

    aes_cozucu dut (
        .clk       (clk),
        .rst       (rst),
        .anahtar   (anahtar),
        .sifre     (sifre),
        .g_gecerli (g_gecerli),
        .hazir     (hazir),
        .blok      (blok),
        .c_gecerli (c_gecerli)
    );

`ifdef AES_ANAHTAR_ONBELLEK_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int LAT_HIT = CACHE ? 11 : 20;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KL = 128'h657870616e642033322d62797465206b;
    localparam logic [127:0] PL = 128'h71776572747975696f70617364666768;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [7:0] sb [256];
    logic [7:0] isb [256];

    task automatic check128(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic checkint(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        while (b != 8'h00) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Walk generator 3 and its inverse in lockstep to fill the S-box.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] c, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk, o;
        rk = round_key(k, 10);
        for (int n = 0; n < 16; n++) s[n] = c[127 - 8 * n -: 8] ^ rk[127 - 8 * n -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int n = 0; n < 16; n++) t[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)] = isb[s[n]];
            rk = round_key(k, r);
            for (int n = 0; n < 16; n++) s[n] = t[n] ^ rk[127 - 8 * n -: 8];
            if (r > 0) begin
                for (int c4 = 0; c4 < 16; c4 += 4) begin
                    a0 = s[c4]; a1 = s[c4 + 1]; a2 = s[c4 + 2]; a3 = s[c4 + 3];
                    s[c4]     = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
                    s[c4 + 1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
                    s[c4 + 2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
                    s[c4 + 3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
                end
            end
        end
        for (int n = 0; n < 16; n++) o[127 - 8 * n -: 8] = s[n];
        return o;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] p, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk, o;
        rk = round_key(k, 0);
        for (int n = 0; n < 16; n++) s[n] = p[127 - 8 * n -: 8] ^ rk[127 - 8 * n -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sb[s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)]];
            if (r < 10) begin
                for (int c4 = 0; c4 < 16; c4 += 4) begin
                    a0 = t[c4]; a1 = t[c4 + 1]; a2 = t[c4 + 2]; a3 = t[c4 + 3];
                    t[c4]     = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    t[c4 + 1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    t[c4 + 2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    t[c4 + 3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            rk = round_key(k, r);
            for (int n = 0; n < 16; n++) s[n] = t[n] ^ rk[127 - 8 * n -: 8];
        end
        for (int n = 0; n < 16; n++) o[127 - 8 * n -: 8] = s[n];
        return o;
    endfunction

    // ---------------- cycle-level scoreboard ----------------
    bit           busy = 1'b0;
    bit           exp_c = 1'b0;
    logic [127:0] exp_blok = '0;
    logic [127:0] m_res = '0;
    int           due = 0;
    bit           m_val = 1'b0;
    bit           m_pend = 1'b0;
    logic [127:0] m_key = '0;

    always @(posedge clk) begin
        cyc++;
        exp_c = 1'b0;
        if (rst) begin
            busy   = 1'b0;
            exp_blok = '0;
            m_val  = 1'b0;
            m_pend = 1'b0;
        end else if (busy) begin
            if (cyc == due) begin
                exp_c    = 1'b1;
                exp_blok = m_res;
                busy     = 1'b0;
                if (m_pend) m_val = 1'b1;
                m_pend = 1'b0;
            end
        end else if (g_gecerli) begin
            busy = 1'b1;
            if (CACHE && m_val && anahtar == m_key) begin
                due = cyc + 11;
            end else begin
                due    = cyc + 20;
                m_key  = anahtar;
                m_val  = 1'b0;
                m_pend = 1'b1;
            end
            m_res = model_dec(sifre, anahtar);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkint("hazir", int'(hazir), int'(!busy));
            checkint("c_gecerli", int'(c_gecerli), int'(exp_c));
            check128("blok", blok, exp_blok);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_pulse(output int t);
        t = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (c_gecerli === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic run_vec(input logic [127:0] k, input logic [127:0] c, input logic [127:0] want,
                           input int lat, input string nm);
        int acc, t;
        @(negedge clk);
        anahtar   = k;
        sifre     = c;
        g_gecerli = 1'b1;
        @(negedge clk);
        g_gecerli = 1'b0;
        acc = cyc;
        wait_pulse(t);
        checkint({nm, " latency"}, (t < 0) ? -1 : t - acc, lat);
        check128({nm, " result"}, blok, want);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int acc, t1, t2, t3, seen;
        logic [127:0] cl;
        build_sbox();

        // Pin the model against published values.
        checkint("sbox[00]", int'(sb[8'h00]), 'h63);
        checkint("sbox[53]", int'(sb[8'h53]), 'hed);
        checkint("inv_sbox[63]", int'(isb[8'h63]), 'h00);
        check128("model C.1", model_dec(C1, K1), P1);
        check128("model B", model_dec(CB, K2), PB);
        check128("model enc C.1", model_enc(P1, K1), C1);
        cl = model_enc(PL, KL);
        check128("model loopback", model_dec(cl, KL), PL);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        checkint("reset hazir", int'(hazir), 1);
        checkint("reset c_gecerli", int'(c_gecerli), 0);
        check128("reset blok", blok, 128'h0);

        run_vec(K1, C1, P1, 20, "C.1");
        run_vec(K2, CB, PB, 20, "FIPS B");
        run_vec(KL, cl, PL, 20, "loopback");

        // Back-to-back with inputs changing mid-operation.
        @(negedge clk);
        anahtar = K1; sifre = C1; g_gecerli = 1'b1;
        @(negedge clk);
        acc = cyc;
        repeat (4) @(negedge clk);
        anahtar = K2; sifre = CB;
        wait_pulse(t1);
        checkint("b2b first latency", (t1 < 0) ? -1 : t1 - acc, 20);
        check128("b2b first result", blok, P1);
        repeat (12) @(negedge clk);
        anahtar = K1; sifre = C1;
        wait_pulse(t2);
        checkint("b2b period 1", (t2 < 0) ? -1 : t2 - t1, 21);
        check128("b2b second result", blok, PB);
        @(negedge clk);
        g_gecerli = 1'b0;
        wait_pulse(t3);
        checkint("b2b period 2", (t3 < 0) ? -1 : t3 - t2, 21);
        check128("b2b third result", blok, P1);

        // Reset during TUR round 5.
        @(negedge clk);
        anahtar = K2; sifre = CB; g_gecerli = 1'b1;
        @(negedge clk);
        g_gecerli = 1'b0;
        acc = cyc;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkint("abort hazir", int'(hazir), 1);
        checkint("abort c_gecerli", int'(c_gecerli), 0);
        check128("abort blok", blok, 128'h0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (c_gecerli === 1'b1) seen++;
        end
        checkint("abort no pulse", seen, 0);
        run_vec(K1, C1, P1, 20, "C.1 after reset");

        // Key cache: repeat key hits, new key misses, reset invalidates.
        run_vec(K1, C1, P1, LAT_HIT, "cache hit 1");
        run_vec(K1, C1, P1, LAT_HIT, "cache hit 2");
        run_vec(K2, CB, PB, 20, "cache new key");
        pulse_reset();
        run_vec(K2, CB, PB, 20, "cache after reset");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
